// File: rtl/fb_arbiter.sv
// fb_arbiter: framebuffer memory arbiter; display tile reads take priority over queued CPU writes
// Ports:
//   I_clk, I_rst                            clock, asynchronous active-high reset
//   I_wr_valid/I_wr_addr/I_wr_data          write offer into the queue; O_wr_ready = queue not full
//   I_blanking, I_hor_cnt                   video timing; tile = I_hor_cnt >> TILE_SHIFT
//   O_mem_req/we/addr/wdata, I_mem_ack/rdata  single-outstanding memory port, one-cycle ack
//   O_color                                 last fetched word, zero-extended to PIX_W
//   O_underrun                              pulse: tile advanced while a fetch was still outstanding
//   O_underrun_cnt, O_fifo_hwm              statistics, live only with FB_ARBITER_STATS_EN defined
module fb_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int TILE_SHIFT = 6,
  parameter int RD_BASE    = 0
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_wr_valid,
  input  logic [ADDR_W-1:0]             I_wr_addr,
  input  logic [DATA_W-1:0]             I_wr_data,
  output logic                          O_wr_ready,
  input  logic                          I_blanking,
  input  logic [11:0]                   I_hor_cnt,
  output logic                          O_mem_req,
  output logic                          O_mem_we,
  output logic [ADDR_W-1:0]             O_mem_addr,
  output logic [DATA_W-1:0]             O_mem_wdata,
  input  logic                          I_mem_ack,
  input  logic [DATA_W-1:0]             I_mem_rdata,
  output logic [PIX_W-1:0]              O_color,
  output logic                          O_underrun,
  output logic [15:0]                   O_underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   O_fifo_hwm
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [11:0] w_tile, r_rd_tile, r_last_tile, r_prev_tile;
  logic r_lt_valid, r_blank_d, r_underrun;
  logic [PIX_W-1:0] r_color;
  logic w_push, w_pop, w_rd_ack, w_rd_go;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_tile     = I_hor_cnt >> TILE_SHIFT;
  assign O_wr_ready = r_count < CW'(FIFO_DEPTH);
  assign w_push     = I_wr_valid && O_wr_ready;
  assign w_pop      = r_state == WR && I_mem_ack;
  assign w_rd_ack   = r_state == RD && I_mem_ack;
  assign w_rd_go    = !I_blanking && (!r_lt_valid || w_tile != r_last_tile);
  // tile is latched on entry to RD so the address stays stable while hor_cnt moves on
  assign w_rd_addr  = ADDR_W'(RD_BASE) + ADDR_W'(r_rd_tile);
  assign O_color    = r_color;
  assign O_underrun = r_underrun;

  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) r_state <= IDLE;
    else r_state <= w_next;

  always_comb
    w_next = r_state == IDLE ? (w_rd_go ? RD : (I_blanking && r_count != '0) ? WR : IDLE)
                             : (I_mem_ack ? IDLE : r_state);

  always_comb begin
    O_mem_req   = r_state != IDLE;
    O_mem_we    = r_state == WR;
    O_mem_addr  = r_state == WR ? r_q_addr[r_rp] : r_state == RD ? w_rd_addr : '0;
    O_mem_wdata = r_state == WR ? r_q_data[r_rp] : '0;
  end

  always_ff @(posedge I_clk)
    if (w_push) begin
      r_q_addr[r_wp] <= I_wr_addr;
      r_q_data[r_wp] <= I_wr_data;
    end

  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      r_blank_d   <= 1'b0;
      r_prev_tile <= '0;
      r_underrun  <= 1'b0;
      r_rd_tile   <= '0;
      r_last_tile <= '0;
      r_lt_valid  <= 1'b0;
      r_color     <= '0;
    end else begin
      r_blank_d   <= I_blanking;
      r_prev_tile <= w_tile;
      r_underrun  <= !I_blanking && r_state != IDLE && w_tile != r_prev_tile;
      if (r_state == IDLE && w_rd_go) r_rd_tile <= w_tile;
      if (w_rd_ack) r_last_tile <= r_rd_tile;
      // a new frame forces the first visible tile to be refetched
      if (I_blanking && !r_blank_d) r_lt_valid <= 1'b0;
      else if (w_rd_ack) r_lt_valid <= 1'b1;
      if (w_rd_ack) r_color <= PIX_W'(I_mem_rdata);
    end

`ifdef FB_ARBITER_STATS_EN
  logic [15:0] r_urun_cnt;
  logic [CW-1:0] r_hwm;
  always_ff @(posedge I_clk or posedge I_rst)
    if (I_rst) begin
      r_urun_cnt <= '0;
      r_hwm      <= '0;
    end else begin
      if (r_underrun && r_urun_cnt != 16'hFFFF) r_urun_cnt <= r_urun_cnt + 16'd1;
      if (r_count > r_hwm) r_hwm <= r_count;
    end
  assign O_underrun_cnt = r_urun_cnt;
  assign O_fifo_hwm     = r_hwm;
`else
  assign O_underrun_cnt = '0;
  assign O_fifo_hwm     = '0;
`endif
endmodule
